// File: rtl/exe_mdu.sv
// Multi-cycle multiply/divide unit for the EXE stage. Owns HI/LO and stalls the
// pipeline while a multiply (1 extra cycle) or radix-2 restoring divide (32 steps) runs.
module exe_mdu #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  EXE_MDUOp,
    input  logic [31:0] EXE_ResultA,
    input  logic [31:0] EXE_ResultB,
    input  logic        EXE_Flush,
    output logic        EXE_Stall,
    output logic [31:0] EXE_HI,
    output logic [31:0] EXE_LO
);

    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;
    localparam logic [4:0] LastIter = 5'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    state_e      state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    // a_q: multiplicand, or dividend shifting out while quotient bits shift in
    logic [31:0] a_q, a_d, b_q, b_d, rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sgn_q, sgn_d, qsign_q, qsign_d, rsign_q, rsign_d;

    logic        start, div_signed;
    logic [63:0] ext_a, ext_b, prod;
    logic [32:0] rem_shift;
    logic        ge;
    logic [31:0] diff, rem_next, quo_next;

    assign start = (state_q == StIdle) && !EXE_Flush &&
                   (EXE_MDUOp >= OpMult) && (EXE_MDUOp <= OpDivu);
    assign div_signed = (EXE_MDUOp == OpDiv);

    assign ext_a = {{32{sgn_q & a_q[31]}}, a_q};
    assign ext_b = {{32{sgn_q & b_q[31]}}, b_q};
    assign prod  = ext_a * ext_b;

    assign rem_shift = {rem_q, a_q[31]};
    assign ge        = rem_shift >= {1'b0, b_q};
    assign diff      = rem_shift[31:0] - b_q;
    assign rem_next  = ge ? diff : rem_shift[31:0];
    assign quo_next  = {a_q[30:0], ge};

    assign EXE_Stall = !rst && !EXE_Flush &&
                       ((start) || (state_q == StDiv && cnt_q != LastIter));
    assign EXE_HI = hi_q;
    assign EXE_LO = lo_q;

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        unique case (state_q)
            StIdle: begin
                if (!EXE_Flush) begin
                    case (EXE_MDUOp)
                        OpMult, OpMultu: begin
                            state_d = StMul;
                            a_d     = EXE_ResultA;
                            b_d     = EXE_ResultB;
                            sgn_d   = (EXE_MDUOp == OpMult);
                        end
                        OpDiv, OpDivu: begin
                            state_d = StDiv;
                            a_d = (div_signed && EXE_ResultA[31]) ? -EXE_ResultA : EXE_ResultA;
                            b_d = (div_signed && EXE_ResultB[31]) ? -EXE_ResultB : EXE_ResultB;
                            // Zero divisor keeps the all-ones quotient unnegated
                            qsign_d = div_signed && (EXE_ResultA[31] ^ EXE_ResultB[31]) &&
                                      (EXE_ResultB != 32'd0);
                            rsign_d = div_signed && EXE_ResultA[31];
                            rem_d   = 32'd0;
                            cnt_d   = 5'd0;
                        end
                        OpMthi:  hi_d = EXE_ResultA;
                        OpMtlo:  lo_d = EXE_ResultA;
                        default: ;
                    endcase
                end
            end
            StMul: begin
                state_d = StIdle;
                if (!EXE_Flush) begin
                    {hi_d, lo_d} = prod;
                end
            end
            StDiv: begin
                if (EXE_Flush) begin
                    state_d = StIdle;
                end else begin
                    rem_d = rem_next;
                    a_d   = quo_next;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LastIter) begin
                        lo_d    = qsign_q ? -quo_next : quo_next;
                        hi_d    = rsign_q ? -rem_next : rem_next;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            rem_q   <= 32'd0;
            cnt_q   <= 5'd0;
            sgn_q   <= 1'b0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
        end
    end

endmodule
